// File: rtl/i2c_master_engine.sv
// Byte-level I2C master engine: START/STOP/READ/WRITE bit sequencing with a
// configurable SCL rate, slave clock stretching with timeout and ACK handling.
module i2c_master_engine #(
  parameter int DIV_BITS    = 7,
  parameter int STRETCH_EN  = 1,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       sdaIn,
  input  logic       sclIn,
  output logic       sdaOutReg,
  output logic       isSending,
  output logic       scl,
  input  logic [1:0] instruction,
  input  logic       enable,
  input  logic       readAck,
  input  logic [7:0] byteToSend,
  output logic [7:0] byteReceived,
  output logic       ackReceived,
  output logic       timeoutErr,
  output logic       complete
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [DIV_BITS-1:0] SAMPLE_DIV = {2'b10, {(DIV_BITS-2){1'b0}}};

  typedef enum logic [2:0] {
    IDLE, START, STOP, READ, WRITE, SEND_ACK, RCV_ACK, DONE
  } state_t;

  state_t              state, state_next;
  logic [DIV_BITS-1:0] div, div_next;
  logic [2:0]          bit_cnt, bit_cnt_next;
  logic [TW-1:0]       stretch_cnt, stretch_cnt_next;
  logic [1:0]          rise_cnt, rise_cnt_next;
  logic [7:0]          tx, tx_next;
  logic                rack, rack_next;
  logic [1:0]          sda_sync, scl_sync;
  logic                scl_next, sda_next, sending_next;
  logic                complete_next, ack_next, tout_next;
  logic [7:0]          rx_next;
  logic [1:0]          quarter;
  logic                busy, stretching, advance, sample_pt, slot_end, scl_high_q;

  assign quarter    = div[DIV_BITS-1 -: 2];
  assign scl_high_q = (quarter == 2'd1) || (quarter == 2'd2);
  assign busy       = (state != IDLE) && (state != DONE);
  // Stretch detection waits until SCL has been released long enough for the
  // pad to be seen through the synchroniser, so our own release is not a stretch.
  assign stretching = (STRETCH_EN != 0) && busy && scl && (rise_cnt == 2'd3) &&
                      !scl_sync[1] && scl_high_q;
  assign advance    = busy && !stretching;
  assign sample_pt  = advance && (div == SAMPLE_DIV);
  assign slot_end   = advance && (&div);

  always_comb begin
    state_next       = state;
    div_next         = div;
    bit_cnt_next     = bit_cnt;
    stretch_cnt_next = '0;
    tx_next          = tx;
    rack_next        = rack;
    scl_next         = scl;
    sda_next         = sdaOutReg;
    sending_next     = isSending;
    rx_next          = byteReceived;
    ack_next         = ackReceived;
    tout_next        = timeoutErr;
    complete_next    = complete;
    rise_cnt_next    = !scl ? 2'd0 : ((rise_cnt == 2'd3) ? 2'd3 : rise_cnt + 2'd1);

    if (advance) div_next = div + 1'b1;
    if (stretching) stretch_cnt_next = stretch_cnt + 1'b1;

    case (state)
      IDLE: begin
        if (enable) begin
          tx_next       = byteToSend;
          rack_next     = readAck;
          complete_next = 1'b0;
          ack_next      = 1'b0;
          tout_next     = 1'b0;
          bit_cnt_next  = 3'd0;
          div_next      = '0;
          case (instruction)
            2'd0:    state_next = START;
            2'd1:    state_next = STOP;
            2'd2:    state_next = READ;
            default: state_next = WRITE;
          endcase
        end
      end
      START: begin
        sending_next = 1'b1;
        case (quarter)
          2'd0:    begin scl_next = 1'b1; sda_next = 1'b1; end
          2'd1:    begin scl_next = 1'b1; sda_next = 1'b0; end
          default: begin scl_next = 1'b0; sda_next = 1'b0; end
        endcase
        if (slot_end) state_next = DONE;
      end
      STOP: begin
        sending_next = 1'b1;
        case (quarter)
          2'd0:    begin scl_next = 1'b0; sda_next = 1'b0; end
          2'd1:    begin scl_next = 1'b1; sda_next = 1'b0; end
          default: begin scl_next = 1'b1; sda_next = 1'b1; end
        endcase
        if (slot_end) state_next = DONE;
      end
      WRITE: begin
        sending_next = 1'b1;
        sda_next     = tx[3'd7 - bit_cnt];
        scl_next     = scl_high_q;
        if (slot_end) begin
          bit_cnt_next = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_next = RCV_ACK;
        end
      end
      READ: begin
        sending_next = 1'b0;
        scl_next     = scl_high_q;
        if (sample_pt) rx_next = {byteReceived[6:0], sda_sync[1]};
        if (slot_end) begin
          bit_cnt_next = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_next = SEND_ACK;
        end
      end
      SEND_ACK: begin
        sending_next = 1'b1;
        sda_next     = ~rack;
        scl_next     = scl_high_q;
        if (slot_end) state_next = DONE;
      end
      RCV_ACK: begin
        sending_next = 1'b0;
        scl_next     = scl_high_q;
        if (sample_pt) ack_next = ~sda_sync[1];
        if (slot_end) state_next = DONE;
      end
      DONE: begin
        complete_next = 1'b1;
        if (!enable) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // A slave that holds SCL too long aborts the command and frees the bus.
    if (stretching && (stretch_cnt == TO_LAST)) begin
      tout_next    = 1'b1;
      scl_next     = 1'b1;
      sending_next = 1'b0;
      state_next   = DONE;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      div          <= '0;
      bit_cnt      <= 3'd0;
      stretch_cnt  <= '0;
      rise_cnt     <= 2'd0;
      tx           <= 8'd0;
      rack         <= 1'b0;
      sda_sync     <= 2'b11;
      scl_sync     <= 2'b11;
      scl          <= 1'b1;
      sdaOutReg    <= 1'b1;
      isSending    <= 1'b0;
      byteReceived <= 8'd0;
      ackReceived  <= 1'b0;
      timeoutErr   <= 1'b0;
      complete     <= 1'b0;
    end else begin
      state        <= state_next;
      div          <= div_next;
      bit_cnt      <= bit_cnt_next;
      stretch_cnt  <= stretch_cnt_next;
      rise_cnt     <= rise_cnt_next;
      tx           <= tx_next;
      rack         <= rack_next;
      sda_sync     <= {sda_sync[0], sdaIn};
      scl_sync     <= {scl_sync[0], sclIn};
      scl          <= scl_next;
      sdaOutReg    <= sda_next;
      isSending    <= sending_next;
      byteReceived <= rx_next;
      ackReceived  <= ack_next;
      timeoutErr   <= tout_next;
      complete     <= complete_next;
    end
  end

endmodule

// File: tb/tb_i2c_master_engine.sv
// Directed bench for i2c_master_engine with an open-drain bus and a simple
// slave model (ACK, read data, clock stretching).
module tb_i2c_master_engine;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       sdaOutReg, isSending, scl_drv;
  logic [1:0] instruction = 2'd0;
  logic       enable = 1'b0;
  logic       readAck = 1'b0;
  logic [7:0] byteToSend = 8'd0;
  logic [7:0] byteReceived;
  logic       ackReceived, timeoutErr, complete;

  logic       slave_sda_low = 1'b0;
  logic       slave_scl_low = 1'b0;
  logic       sda_bus, scl_bus;
  int         slave_mode = 0;      // 0 idle, 1 ack slave, 2 read slave, 3 capture only
  int         stretch_len = 0;     // 0 none, >0 cycles, -1 until released
  logic       stretch_release = 1'b0;
  logic [7:0] rd_byte = 8'd0;
  int         fall_n = 0;
  logic [8:0] cap_bits = 9'd0;
  logic       sda_fall_scl = 1'b0;
  logic       sda_rise_scl = 1'b0;

  int nvec = 0;
  int nmis = 0;

  assign sda_bus = ~((isSending & ~sdaOutReg) | slave_sda_low);
  assign scl_bus = scl_drv & ~slave_scl_low;

  always #5 clk = ~clk;

  i2c_master_engine #(.DIV_BITS(7), .STRETCH_EN(1), .TIMEOUT_CYC(300)) dut (
    .clk(clk), .resetn(resetn), .sdaIn(sda_bus), .sclIn(scl_bus),
    .sdaOutReg(sdaOutReg), .isSending(isSending), .scl(scl_drv),
    .instruction(instruction), .enable(enable), .readAck(readAck),
    .byteToSend(byteToSend), .byteReceived(byteReceived),
    .ackReceived(ackReceived), .timeoutErr(timeoutErr), .complete(complete)
  );

  always @(negedge sda_bus) sda_fall_scl = scl_bus;
  always @(posedge sda_bus) sda_rise_scl = scl_bus;

  always @(posedge scl_bus) begin
    if (slave_mode != 0) cap_bits = {cap_bits[7:0], sda_bus};
  end

  always @(negedge scl_bus) begin
    if (slave_mode != 0) begin
      fall_n = fall_n + 1;
      if (slave_mode == 1) begin
        if (fall_n == 8) slave_sda_low = 1'b1;
        else if (fall_n == 9) slave_sda_low = 1'b0;
      end else if (slave_mode == 2) begin
        if (fall_n <= 7) slave_sda_low = ~rd_byte[7-fall_n];
        else if (fall_n == 8) slave_sda_low = 1'b0;
      end
      if (fall_n == 3 && stretch_len != 0) begin
        slave_scl_low = 1'b1;
        for (int i = 0; i < 1000 && scl_drv !== 1'b1; i++) @(negedge clk);
        if (stretch_len > 0) repeat (stretch_len) @(negedge clk);
        else wait (stretch_release);
        slave_scl_low = 1'b0;
      end
    end
  end

  task automatic run_cmd(input logic [1:0] ins, input logic [7:0] b, input logic ra,
                         input int limit, output int cyc);
    @(negedge clk);
    instruction = ins; byteToSend = b; readAck = ra; enable = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
      if (cyc == 3) begin instruction = ~ins; byteToSend = ~b; readAck = ~ra; end
    end while (!complete && cyc < limit);
    nvec++;
    if (complete !== 1'b1) begin
      nmis++; $display("FAIL cmd_done: complete=%b after %0d cycles, want 1", complete, cyc);
    end
    $display("cmd=%0d data=%02h cycles=%0d rx=%02h ack=%b tout=%b", ins, b, cyc,
             byteReceived, ackReceived, timeoutErr);
    @(negedge clk); enable = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nvec++; if (scl_drv !== 1'b1) begin nmis++; $display("FAIL rst_scl: got %b want 1", scl_drv); end
    nvec++; if (sdaOutReg !== 1'b1) begin nmis++; $display("FAIL rst_sda: got %b want 1", sdaOutReg); end
    nvec++; if (isSending !== 1'b0) begin nmis++; $display("FAIL rst_sending: got %b want 0", isSending); end
    nvec++; if (complete !== 1'b0) begin nmis++; $display("FAIL rst_complete: got %b want 0", complete); end
    nvec++; if ({byteReceived, ackReceived, timeoutErr} !== 10'd0) begin
      nmis++; $display("FAIL rst_status: got %02h/%b/%b want 00/0/0", byteReceived, ackReceived, timeoutErr);
    end
    @(negedge clk); resetn = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_start_stop();
    int cyc;
    sda_fall_scl = 1'b0;
    run_cmd(2'd0, 8'h00, 1'b0, 500, cyc);
    nvec++; if (cyc !== 130) begin nmis++; $display("FAIL start_latency: got %0d want 130", cyc); end
    nvec++; if (sda_fall_scl !== 1'b1) begin nmis++; $display("FAIL start_cond: scl at sda fall %b want 1", sda_fall_scl); end
    nvec++; if ({scl_drv, sdaOutReg} !== 2'b00) begin nmis++; $display("FAIL start_hold: scl/sda %b%b want 00", scl_drv, sdaOutReg); end
    sda_rise_scl = 1'b0;
    run_cmd(2'd1, 8'h00, 1'b0, 500, cyc);
    nvec++; if (cyc !== 130) begin nmis++; $display("FAIL stop_latency: got %0d want 130", cyc); end
    nvec++; if (sda_rise_scl !== 1'b1) begin nmis++; $display("FAIL stop_cond: scl at sda rise %b want 1", sda_rise_scl); end
    nvec++; if ({scl_drv, sdaOutReg} !== 2'b11) begin nmis++; $display("FAIL stop_idle: scl/sda %b%b want 11", scl_drv, sdaOutReg); end
  endtask

  task automatic test_write(input logic [7:0] b, input int mode, input logic exp_ack);
    int cyc;
    run_cmd(2'd0, 8'h00, 1'b0, 500, cyc);
    slave_mode = mode; fall_n = 0; cap_bits = 9'd0;
    run_cmd(2'd3, b, 1'b0, 2000, cyc);
    nvec++; if (cyc !== 1154) begin nmis++; $display("FAIL write_latency: got %0d want 1154", cyc); end
    nvec++; if (cap_bits[8:1] !== b) begin nmis++; $display("FAIL write_bits: got %02h want %02h", cap_bits[8:1], b); end
    nvec++; if (cap_bits[0] !== ~exp_ack) begin nmis++; $display("FAIL write_ackslot: sda %b want %b", cap_bits[0], ~exp_ack); end
    nvec++; if (ackReceived !== exp_ack) begin nmis++; $display("FAIL write_ack: got %b want %b", ackReceived, exp_ack); end
    nvec++; if (timeoutErr !== 1'b0) begin nmis++; $display("FAIL write_tout: got %b want 0", timeoutErr); end
    slave_mode = 0; slave_sda_low = 1'b0;
    run_cmd(2'd1, 8'h00, 1'b0, 500, cyc);
  endtask

  task automatic test_read(input logic [7:0] b, input logic ra);
    int cyc;
    run_cmd(2'd0, 8'h00, 1'b0, 500, cyc);
    rd_byte = b; slave_mode = 2; fall_n = 0; cap_bits = 9'd0;
    slave_sda_low = ~b[7];
    run_cmd(2'd2, 8'h00, ra, 2000, cyc);
    nvec++; if (cyc !== 1154) begin nmis++; $display("FAIL read_latency: got %0d want 1154", cyc); end
    nvec++; if (byteReceived !== b) begin nmis++; $display("FAIL read_data: got %02h want %02h", byteReceived, b); end
    nvec++; if (cap_bits[0] !== ~ra) begin nmis++; $display("FAIL read_ackslot: sda %b want %b", cap_bits[0], ~ra); end
    slave_mode = 0; slave_sda_low = 1'b0;
    run_cmd(2'd1, 8'h00, 1'b0, 500, cyc);
  endtask

  task automatic test_back_to_back();
    int cyc;
    @(negedge clk);
    instruction = 2'd0; enable = 1'b1;
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (!complete && cyc < 500);
    nvec++; if (cyc !== 130) begin nmis++; $display("FAIL hold_start_latency: got %0d want 130", cyc); end
    repeat (40) @(posedge clk);
    #1;
    nvec++; if (complete !== 1'b1) begin nmis++; $display("FAIL hold_complete: got %b want 1", complete); end
    nvec++; if (scl_drv !== 1'b0) begin nmis++; $display("FAIL hold_no_retrigger: scl %b want 0", scl_drv); end
    @(negedge clk); enable = 1'b0;
    @(posedge clk); #1;
    run_cmd(2'd1, 8'h00, 1'b0, 500, cyc);
    nvec++; if (cyc !== 130) begin nmis++; $display("FAIL b2b_stop_latency: got %0d want 130", cyc); end
  endtask

  task automatic test_stretch();
    int cyc;
    run_cmd(2'd0, 8'h00, 1'b0, 500, cyc);
    slave_mode = 1; fall_n = 0; cap_bits = 9'd0; stretch_len = 200;
    run_cmd(2'd3, 8'h96, 1'b0, 3000, cyc);
    nvec++; if (cyc < 1350 || cyc > 1356) begin nmis++; $display("FAIL stretch_latency: got %0d want 1350..1356", cyc); end
    nvec++; if (cap_bits[8:1] !== 8'h96) begin nmis++; $display("FAIL stretch_bits: got %02h want 96", cap_bits[8:1]); end
    nvec++; if ({ackReceived, timeoutErr} !== 2'b10) begin nmis++; $display("FAIL stretch_status: ack/tout %b%b want 10", ackReceived, timeoutErr); end
    slave_mode = 0; slave_sda_low = 1'b0; stretch_len = 0;
    run_cmd(2'd1, 8'h00, 1'b0, 500, cyc);
  endtask

  task automatic test_timeout();
    int cyc;
    run_cmd(2'd0, 8'h00, 1'b0, 500, cyc);
    slave_mode = 1; fall_n = 0; stretch_len = -1; stretch_release = 1'b0;
    run_cmd(2'd3, 8'hF0, 1'b0, 3000, cyc);
    nvec++; if (timeoutErr !== 1'b1) begin nmis++; $display("FAIL tout_flag: got %b want 1", timeoutErr); end
    nvec++; if (scl_drv !== 1'b1) begin nmis++; $display("FAIL tout_scl: got %b want 1", scl_drv); end
    nvec++; if (isSending !== 1'b0) begin nmis++; $display("FAIL tout_sending: got %b want 0", isSending); end
    stretch_release = 1'b1;
    repeat (2) @(negedge clk);
    stretch_release = 1'b0; stretch_len = 0; slave_mode = 0; slave_sda_low = 1'b0;
    run_cmd(2'd1, 8'h00, 1'b0, 500, cyc);
    nvec++; if (timeoutErr !== 1'b0) begin nmis++; $display("FAIL tout_clear: got %b want 0", timeoutErr); end
  endtask

  task automatic test_reset_mid_read();
    int cyc;
    run_cmd(2'd0, 8'h00, 1'b0, 500, cyc);
    rd_byte = 8'h5A; slave_mode = 2; fall_n = 0; slave_sda_low = ~rd_byte[7];
    @(negedge clk);
    instruction = 2'd2; readAck = 1'b1; enable = 1'b1;
    repeat (356) @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    nvec++; if (scl_drv !== 1'b1) begin nmis++; $display("FAIL mid_rst_scl: got %b want 1", scl_drv); end
    nvec++; if ({isSending, complete} !== 2'b00) begin nmis++; $display("FAIL mid_rst_flags: sending/complete %b%b want 00", isSending, complete); end
    nvec++; if (byteReceived !== 8'h00) begin nmis++; $display("FAIL mid_rst_rx: got %02h want 00", byteReceived); end
    enable = 1'b0; slave_mode = 0; slave_sda_low = 1'b0;
    @(negedge clk); resetn = 1'b1;
    repeat (2) @(posedge clk);
    sda_fall_scl = 1'b0;
    run_cmd(2'd0, 8'h00, 1'b0, 500, cyc);
    nvec++; if (cyc !== 130) begin nmis++; $display("FAIL post_rst_start: got %0d want 130", cyc); end
    nvec++; if (sda_fall_scl !== 1'b1) begin nmis++; $display("FAIL post_rst_cond: scl at sda fall %b want 1", sda_fall_scl); end
    run_cmd(2'd1, 8'h00, 1'b0, 500, cyc);
  endtask

  initial begin
    test_reset();
    test_start_stop();
    test_write(8'hA5, 1, 1'b1);
    test_write(8'h3C, 3, 1'b0);
    test_read(8'h5A, 1'b0);
    test_read(8'hC3, 1'b1);
    test_back_to_back();
    test_stretch();
    test_timeout();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
